// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gpu_pkg
//  Description : Shared opcodes, FSM state encoding and default geometry for
//                the GPU text-mode command engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  // Default screen geometry
  localparam int COLS_DEF   = 40;
  localparam int ROWS_DEF   = 25;
  localparam int CHAR_W_DEF = 8;

  // Command opcodes (low byte of the opcode word; high byte must be zero)
  localparam logic [7:0] OP_CLR  = 8'hC0;  // clear screen (param must be 0)
  localparam logic [7:0] OP_PUT  = 8'hC1;  // put character, advance cursor
  localparam logic [7:0] OP_BS   = 8'hC2;  // backspace
  localparam logic [7:0] OP_SETY = 8'hC3;  // set row, clamped
  localparam logic [7:0] OP_SETX = 8'hC4;  // set column, clamped
  localparam logic [7:0] OP_CLRH = 8'hC5;  // clear + home
  localparam logic [7:0] OP_NL   = 8'hC6;  // newline

  // Engine FSM states
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PARAM       = 3'd1,
    ST_EXEC        = 3'd2,
    ST_CLEAR       = 3'd3,
    ST_SCROLL_RD   = 3'd4,
    ST_SCROLL_WR   = 3'd5,
    ST_SCROLL_FILL = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gpu_text_engine_if.sv
`default_nettype none
// ============================================================================
//  Interface   : gpu_text_engine_if
//  Description : CPU-to-engine command word stream with valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpu_text_engine_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;

  // CPU side drives the words
  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  // Engine side accepts the words
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/gpu_char_ram.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_char_ram
//  Description : Character RAM, DEPTH x CHAR_W. Engine port read/write, display
//                port read-only. Both reads are registered and return the value
//                held before a same-cycle write. Contents are not reset; only
//                the display read register clears on reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_char_ram #(
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10,
  parameter int CHAR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              clr,
  input  wire logic              e_we_i,
  input  wire logic [ADDR_W-1:0] e_addr_i,
  input  wire logic [CHAR_W-1:0] e_wdata_i,
  output logic      [CHAR_W-1:0] e_rdata_o,
  input  wire logic [ADDR_W-1:0] d_addr_i,
  output logic      [CHAR_W-1:0] d_rdata_o
);

  logic [CHAR_W-1:0] mem_q [DEPTH];

  // Engine-port write into the cell array
  always_ff @(posedge clk) begin
    if (e_we_i) begin
      mem_q[e_addr_i] <= e_wdata_i;
    end
  end

  // Engine-port registered read (used by the scroll copy)
  always_ff @(posedge clk) begin
    e_rdata_o <= mem_q[e_addr_i];
  end

  // Display-port registered read, cleared on reset
  always_ff @(posedge clk) begin
    if (!clr) begin
      d_rdata_o <= '0;
    end else begin
      d_rdata_o <= mem_q[d_addr_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpu_text_engine.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_text_engine
//  Description : Text-mode command engine. Takes opcode/param word pairs,
//                maintains a cursor and writes a COLS x ROWS character RAM
//                that the VGA pipeline reads through an independent port.
//  Options     : GPU_SCROLL_EN - cursor overflow scrolls the screen up one row
//                instead of wrapping the cursor to (0,0).
//  Revision    : 1.0 - initial release
// ============================================================================
module gpu_text_engine
  import gpu_pkg::*;
#(
  parameter  int COLS   = COLS_DEF,
  parameter  int ROWS   = ROWS_DEF,
  parameter  int CHAR_W = CHAR_W_DEF,
  localparam int ADDR_W = $clog2(COLS * ROWS)
) (
  input  wire logic              clk,
  input  wire logic              clr,
  gpu_text_engine_if.slave       cmd,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output logic      [CHAR_W-1:0] rd_data,
  output logic      [ADDR_W-1:0] cur_x,
  output logic      [ADDR_W-1:0] cur_y,
  output logic                   busy,
  output logic                   err
);

  localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_cols      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] c_last_col  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] c_last_row  = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] c_last_cell = ADDR_W'(COLS * ROWS - 1);
  // Last cell of the rows that receive a copy of the row below during scroll
  localparam logic [ADDR_W-1:0] c_body_last = ADDR_W'(COLS * (ROWS - 1) - 1);

  state_t            state_q, state_d;
  logic [15:0]       op_q, op_d;
  logic [15:0]       param_q, param_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              w_xfer;
  logic [ADDR_W-1:0] w_ptr;
  logic [7:0]        w_opc;
  logic              w_bad;
  logic              w_at_home;
  logic              w_ovf;
  logic [ADDR_W-1:0] w_sety;
  logic [ADDR_W-1:0] w_setx;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [CHAR_W-1:0] w_wdata;
  logic [CHAR_W-1:0] w_rdata;

  assign w_xfer    = cmd.cmd_valid & cmd.cmd_ready;
  // Linear cell address of the cursor; constant multiply, wraps to ADDR_W
  assign w_ptr     = y_q * c_cols + x_q;
  assign w_opc     = op_q[7:0];
  assign w_bad     = (op_q[15:8] != 8'h00) || (w_opc < OP_CLR) || (w_opc > OP_NL)
                   || ((w_opc == OP_CLR) && (param_q != 16'h0000));
  assign w_at_home = (x_q == '0) && (y_q == '0);
  assign w_ovf     = ((w_opc == OP_PUT) && (x_q == c_last_col) && (y_q == c_last_row))
                   || ((w_opc == OP_NL) && (y_q == c_last_row));
  assign w_sety    = (param_q > 16'(ROWS - 1)) ? c_last_row : param_q[ADDR_W-1:0];
  assign w_setx    = (param_q > 16'(COLS - 1)) ? c_last_col : param_q[ADDR_W-1:0];

  assign cur_x = x_q;
  assign cur_y = y_q;

  // State register: FSM state, latched command words, cursor, sweep counter
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      param_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      param_q <= param_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: word capture, command execution, clear/scroll sweeps
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    param_d = param_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_xfer) begin
          op_d    = cmd.cmd_data;
          state_d = ST_PARAM;
        end
      end
      ST_PARAM: begin
        if (w_xfer) begin
          param_d = cmd.cmd_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (!w_bad) begin
          if (w_ovf) begin
`ifdef GPU_SCROLL_EN
            state_d = ST_SCROLL_RD;
            cnt_d   = '0;
`else
            x_d = '0;
            y_d = '0;
`endif
          end else begin
            case (w_opc)
              OP_CLR, OP_CLRH: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                x_d     = '0;
                y_d     = '0;
              end
              OP_PUT: begin
                if (x_q == c_last_col) begin
                  x_d = '0;
                  y_d = y_q + c_one;
                end else begin
                  x_d = x_q + c_one;
                end
              end
              OP_BS: begin
                if (!w_at_home) begin
                  if (x_q == '0) begin
                    x_d = c_last_col;
                    y_d = y_q - c_one;
                  end else begin
                    x_d = x_q - c_one;
                  end
                end
              end
              OP_SETY: y_d = w_sety;
              OP_SETX: x_d = w_setx;
              OP_NL: begin
                x_d = '0;
                y_d = y_q + c_one;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        if (cnt_q == c_last_cell) begin
          state_d = ST_IDLE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      ST_SCROLL_RD: state_d = ST_SCROLL_WR;
      ST_SCROLL_WR: begin
        cnt_d   = cnt_q + c_one;
        state_d = (cnt_q == c_body_last) ? ST_SCROLL_FILL : ST_SCROLL_RD;
      end
      ST_SCROLL_FILL: begin
        if (cnt_q == c_last_cell) begin
          state_d = ST_IDLE;
          x_d     = '0;
          y_d     = c_last_row;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshake, status flags and the engine-side RAM port
  always_comb begin
    cmd.cmd_ready = clr && ((state_q == ST_IDLE) || (state_q == ST_PARAM));
    busy          = (state_q == ST_CLEAR) || (state_q == ST_SCROLL_RD)
                 || (state_q == ST_SCROLL_WR) || (state_q == ST_SCROLL_FILL);
    err           = (state_q == ST_EXEC) && w_bad;
    w_we          = 1'b0;
    w_addr        = w_ptr;
    w_wdata       = '0;
    case (state_q)
      ST_EXEC: begin
        if (!w_bad) begin
          if (w_opc == OP_PUT) begin
            w_we    = 1'b1;
            w_wdata = param_q[CHAR_W-1:0];
          end else if ((w_opc == OP_BS) && !w_at_home) begin
            w_we   = 1'b1;
            w_addr = w_ptr - c_one;
          end
        end
      end
      ST_CLEAR: begin
        w_we   = 1'b1;
        w_addr = cnt_q;
      end
      ST_SCROLL_RD: w_addr = cnt_q + c_cols;
      ST_SCROLL_WR: begin
        w_we    = 1'b1;
        w_addr  = cnt_q;
        w_wdata = w_rdata;
      end
      ST_SCROLL_FILL: begin
        w_we   = 1'b1;
        w_addr = cnt_q;
      end
      default: ;
    endcase
  end

  // Writes are suppressed on the reset edge so an interrupted sweep stops at once
  gpu_char_ram #(
    .DEPTH  (COLS * ROWS),
    .ADDR_W (ADDR_W),
    .CHAR_W (CHAR_W)
  ) u_ram (
    .clk       (clk),
    .clr       (clr),
    .e_we_i    (w_we & clr),
    .e_addr_i  (w_addr),
    .e_wdata_i (w_wdata),
    .e_rdata_o (w_rdata),
    .d_addr_i  (rd_addr),
    .d_rdata_o (rd_data)
  );

endmodule
`default_nettype wire
